// File: rtl/select_seq_if.sv
// rtl/select_seq_if.sv - request, strobe, memory and completion signals of the select sequencer
interface select_seq_if;
    logic       req_arr_sel_from_pnl;
    logic       req_strt_from_pu;
    logic       req_addr1_from_pu;
    logic       req_addr2_from_pu;
    logic       req_addr2_from_io;
    logic       hold_from_pnl;
    logic       clear_err_from_pnl;
    logic       mem_ack_from_mem;

    logic       do_arr_sel_to_sel;
    logic       do_strt_to_sel;
    logic       do_addr1_to_sel;
    logic       do_addr2_to_sel_pu;
    logic       do_addr2_to_sel_io;
    logic       mem_req_to_mem;
    logic       done_to_pnl;
    logic       done_to_pu;
    logic       done_to_io;
    logic       busy;
    logic [4:0] pending_to_pnl;
    logic       timeout_err_to_pnl;

    modport master (
        output req_arr_sel_from_pnl, req_strt_from_pu, req_addr1_from_pu,
               req_addr2_from_pu, req_addr2_from_io, hold_from_pnl,
               clear_err_from_pnl, mem_ack_from_mem,
        input  do_arr_sel_to_sel, do_strt_to_sel, do_addr1_to_sel,
               do_addr2_to_sel_pu, do_addr2_to_sel_io, mem_req_to_mem,
               done_to_pnl, done_to_pu, done_to_io, busy, pending_to_pnl,
               timeout_err_to_pnl
    );

    modport slave (
        input  req_arr_sel_from_pnl, req_strt_from_pu, req_addr1_from_pu,
               req_addr2_from_pu, req_addr2_from_io, hold_from_pnl,
               clear_err_from_pnl, mem_ack_from_mem,
        output do_arr_sel_to_sel, do_strt_to_sel, do_addr1_to_sel,
               do_addr2_to_sel_pu, do_addr2_to_sel_io, mem_req_to_mem,
               done_to_pnl, done_to_pu, done_to_io, busy, pending_to_pnl,
               timeout_err_to_pnl
    );
endinterface

// File: rtl/select_seq.sv
// rtl/select_seq.sv - fixed-priority sequencer for select register loads and memory reads
module select_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        resetn,
    select_seq_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_MEM  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [8:0] TO_LIMIT = TIMEOUT[8:0];

    logic [1:0] state;
    logic [4:0] pending;
    logic [4:0] grant;
    logic [7:0] cnt;
    logic       err;

    logic [4:0] req_vec;
    logic [4:0] winner;
    logic [4:0] served;
    logic       start;
    logic       mem_grant;
    logic       cnt_hit;
    logic       to_fire;

    // Bit order matches pending_to_pnl: {io_addr2, pu_addr2, addr1, strt, arr_sel}
    assign req_vec = {bus.req_addr2_from_io, bus.req_addr2_from_pu,
                      bus.req_addr1_from_pu, bus.req_strt_from_pu,
                      bus.req_arr_sel_from_pnl};

    // Lowest set bit wins, which is the arr_sel-first priority order
    assign winner    = pending & (~pending + 5'd1);
    assign start     = (state == S_IDLE) && !bus.hold_from_pnl && (|pending);
    assign served    = start ? winner : 5'b00000;
    assign mem_grant = grant[2] | grant[3] | grant[4];
    assign cnt_hit   = (({1'b0, cnt} + 9'd1) == TO_LIMIT);
    assign to_fire   = (state == S_MEM) && !bus.mem_ack_from_mem && cnt_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            pending <= 5'b00000;
            grant   <= 5'b00000;
            cnt     <= 8'd0;
            err     <= 1'b0;
        end else begin
            // A request still high on the grant edge re-arms its own bit
            pending <= (pending & ~served) | req_vec;

            if (to_fire) begin
                err <= 1'b1;
            end else if (bus.clear_err_from_pnl) begin
                err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        grant <= winner;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt   <= 8'd0;
                    state <= mem_grant ? S_MEM : S_DONE;
                end
                S_MEM: begin
                    cnt <= cnt + 8'd1;
                    if (bus.mem_ack_from_mem || cnt_hit) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.do_arr_sel_to_sel  = (state == S_LOAD) & grant[0];
    assign bus.do_strt_to_sel     = (state == S_LOAD) & grant[1];
    assign bus.do_addr1_to_sel    = (state == S_LOAD) & grant[2];
    assign bus.do_addr2_to_sel_pu = (state == S_LOAD) & grant[3];
    assign bus.do_addr2_to_sel_io = (state == S_LOAD) & grant[4];

    assign bus.mem_req_to_mem     = (state == S_MEM);

    assign bus.done_to_pnl        = (state == S_DONE) & grant[0];
    assign bus.done_to_pu         = (state == S_DONE) & (grant[1] | grant[2] | grant[3]);
    assign bus.done_to_io         = (state == S_DONE) & grant[4];

    assign bus.busy               = (state != S_IDLE);
    assign bus.pending_to_pnl     = pending;
    assign bus.timeout_err_to_pnl = err;
endmodule

// File: tb/tb_select_seq.sv
// tb/tb_select_seq.sv - directed self-checking bench for select_seq
module tb_select_seq;
    logic clk;
    logic resetn;

    select_seq_if sq ();

    select_seq #(.TIMEOUT(15)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (sq.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int n_strobe   = 0;
    int n_multi    = 0;
    int n_mem      = 0;
    int n_done_pnl = 0;
    int n_done_pu  = 0;
    int n_done_io  = 0;
    logic err_at_done = 1'b0;
    int strobe_q[$];
    int s_cnt;

    always @(negedge clk) begin
        s_cnt = int'(sq.do_arr_sel_to_sel) + int'(sq.do_strt_to_sel) + int'(sq.do_addr1_to_sel)
              + int'(sq.do_addr2_to_sel_pu) + int'(sq.do_addr2_to_sel_io);
        if (s_cnt > 1) n_multi++;
        if (s_cnt == 1) begin
            n_strobe++;
            if (sq.do_arr_sel_to_sel)  strobe_q.push_back(0);
            if (sq.do_strt_to_sel)     strobe_q.push_back(1);
            if (sq.do_addr1_to_sel)    strobe_q.push_back(2);
            if (sq.do_addr2_to_sel_pu) strobe_q.push_back(3);
            if (sq.do_addr2_to_sel_io) strobe_q.push_back(4);
        end
        if (sq.mem_req_to_mem) n_mem++;
        if (sq.done_to_pnl) n_done_pnl++;
        if (sq.done_to_io)  n_done_io++;
        if (sq.done_to_pu) begin
            n_done_pu++;
            err_at_done = sq.timeout_err_to_pnl;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {sq.do_arr_sel_to_sel, sq.do_strt_to_sel, sq.do_addr1_to_sel,
                sq.do_addr2_to_sel_pu, sq.do_addr2_to_sel_io, sq.mem_req_to_mem,
                sq.done_to_pnl, sq.done_to_pu, sq.done_to_io, sq.busy,
                sq.pending_to_pnl, sq.timeout_err_to_pnl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] v);
        {sq.req_addr2_from_io, sq.req_addr2_from_pu, sq.req_addr1_from_pu,
         sq.req_strt_from_pu, sq.req_arr_sel_from_pnl} = v;
    endtask

    task automatic pulse(input logic [4:0] v);
        set_req(v);
        tick();
        set_req(5'b00000);
    endtask

    // Serves memory grants, acking at the end of the ack_at-th mem_req cycle (0 = never)
    task automatic run(input int ack_at, input int budget);
        int mcnt = 0;
        bit fin = 0;
        for (int i = 0; i < budget && !fin; i++) begin
            tick();
            mcnt = sq.mem_req_to_mem ? mcnt + 1 : 0;
            sq.mem_ack_from_mem = (ack_at > 0) && (mcnt == ack_at);
            if (!sq.busy && sq.pending_to_pnl == 5'b00000) fin = 1;
        end
        sq.mem_ack_from_mem = 1'b0;
        if (!fin) check("run_budget", {sq.busy, sq.pending_to_pnl}, 0);
    endtask

    int b_str, b_mem, b_pnl, b_pu, b_io, b_q;

    task automatic snap();
        b_str = n_strobe; b_mem = n_mem; b_pnl = n_done_pnl;
        b_pu = n_done_pu; b_io = n_done_io; b_q = strobe_q.size();
    endtask

    initial begin
        resetn = 1'b0;
        set_req(5'b00000);
        sq.hold_from_pnl      = 1'b0;
        sq.clear_err_from_pnl = 1'b0;
        sq.mem_ack_from_mem   = 1'b0;

        // Reset state
        tick(); tick();
        check("reset_outs", outs(), 16'h0000);
        resetn = 1'b1;
        check("release_outs", outs(), 16'h0000);
        tick();
        check("idle_outs", outs(), 16'h0000);

        // Single panel request, step by step
        snap();
        pulse(5'b00001);
        check("pnl_pending", sq.pending_to_pnl, 5'b00001);
        check("pnl_no_strobe_e0", sq.do_arr_sel_to_sel, 0);
        tick();
        check("pnl_strobe_e1", sq.do_arr_sel_to_sel, 1);
        check("pnl_busy_e1", sq.busy, 1);
        check("pnl_pending_cleared", sq.pending_to_pnl, 5'b00000);
        tick();
        check("pnl_strobe_e2", sq.do_arr_sel_to_sel, 0);
        check("pnl_done_e2", sq.done_to_pnl, 1);
        tick();
        check("pnl_done_e3", sq.done_to_pnl, 0);
        check("pnl_busy_e3", sq.busy, 0);
        check("pnl_no_mem", n_mem - b_mem, 0);
        check("pnl_one_strobe", n_strobe - b_str, 1);

        // All five at once
        snap();
        pulse(5'b11111);
        run(2, 300);
        check("all_strobes", n_strobe - b_str, 5);
        for (int k = 0; k < 5; k++) begin
            if (strobe_q.size() > b_q + k) check($sformatf("all_order%0d", k), strobe_q[b_q + k], k);
            else check($sformatf("all_order%0d_missing", k), strobe_q.size(), b_q + k + 1);
        end
        check("all_done_pu", n_done_pu - b_pu, 3);
        check("all_done_pnl", n_done_pnl - b_pnl, 1);
        check("all_done_io", n_done_io - b_io, 1);
        check("all_mem_cycles", n_mem - b_mem, 6);

        // Timeout with clear held high: set wins on its edge, clear acts on the next
        snap();
        sq.clear_err_from_pnl = 1'b1;
        pulse(5'b00100);
        run(0, 100);
        check("toA_mem_cycles", n_mem - b_mem, 15);
        check("toA_err_at_done", err_at_done, 1);
        check("toA_err_cleared", sq.timeout_err_to_pnl, 0);
        sq.clear_err_from_pnl = 1'b0;

        // Timeout, flag sticks until cleared
        snap();
        pulse(5'b00100);
        run(0, 100);
        check("toB_mem_cycles", n_mem - b_mem, 15);
        check("toB_done_pu", n_done_pu - b_pu, 1);
        check("toB_err", sq.timeout_err_to_pnl, 1);
        repeat (5) tick();
        check("toB_err_sticky", sq.timeout_err_to_pnl, 1);
        sq.clear_err_from_pnl = 1'b1;
        tick();
        sq.clear_err_from_pnl = 1'b0;
        check("toB_err_clear", sq.timeout_err_to_pnl, 0);

        // Ack on the timeout edge is a success
        snap();
        pulse(5'b01000);
        run(15, 100);
        check("ackedge_mem_cycles", n_mem - b_mem, 15);
        check("ackedge_done_pu", n_done_pu - b_pu, 1);
        check("ackedge_err_at_done", err_at_done, 0);
        check("ackedge_err", sq.timeout_err_to_pnl, 0);

        // Spurious ack while idle
        snap();
        sq.mem_ack_from_mem = 1'b1;
        repeat (4) tick();
        sq.mem_ack_from_mem = 1'b0;
        check("spur_outs", outs(), 16'h0000);
        check("spur_done", (n_done_pu - b_pu) + (n_done_pnl - b_pnl) + (n_done_io - b_io), 0);

        // Hold
        snap();
        sq.hold_from_pnl = 1'b1;
        pulse(5'b10000);
        pulse(5'b00010);
        tick(); tick();
        check("hold_pending", sq.pending_to_pnl, 5'b10010);
        check("hold_no_strobe", n_strobe - b_str, 0);
        check("hold_busy", sq.busy, 0);
        sq.hold_from_pnl = 1'b0;
        run(2, 100);
        check("hold_strobes", n_strobe - b_str, 2);
        if (strobe_q.size() >= b_q + 2) begin
            check("hold_first", strobe_q[b_q], 1);
            check("hold_second", strobe_q[b_q + 1], 4);
        end else check("hold_order_missing", strobe_q.size(), b_q + 2);
        check("hold_done_pu", n_done_pu - b_pu, 1);
        check("hold_done_io", n_done_io - b_io, 1);

        // Reset in the middle of a memory cycle, with other requests arriving
        pulse(5'b01000);
        for (int i = 0; i < 10 && !sq.mem_req_to_mem; i++) begin
            set_req(5'($urandom_range(0, 31)));
            tick();
        end
        check("rst_in_mem", sq.mem_req_to_mem, 1);
        set_req(5'($urandom_range(0, 31)));
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async_outs", outs(), 16'h0000);
        set_req(5'b00000);
        tick(); tick();
        check("rst_low_outs", outs(), 16'h0000);
        snap();
        resetn = 1'b1;
        check("rst_release_outs", outs(), 16'h0000);
        repeat (6) tick();
        check("rst_no_done", (n_done_pu - b_pu) + (n_done_pnl - b_pnl) + (n_done_io - b_io), 0);
        check("rst_no_strobe", n_strobe - b_str, 0);

        check("never_two_strobes", n_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/select_seq.md
# select_seq

Sequencer and arbiter for the select register. Collects load requests from the control panel, the program unit (PU) and the I/O unit, and grants them one at a time by fixed priority. For each grant it issues exactly one single-cycle `do_*` load strobe to the select register. For address loads it then runs a memory read handshake with a timeout, and finally returns a completion pulse to the requester's unit.

## Interface

Parameters:
- `TIMEOUT`, default 15: maximum cycles `mem_req_to_mem` stays high without an ack. Range 1..255.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge
- `resetn`  in  1  asynchronous active-low reset
- `req_arr_sel_from_pnl`  in  1  panel request: load select register, no memory cycle
- `req_strt_from_pu`  in  1  PU request: start-register load, no memory cycle
- `req_addr1_from_pu`  in  1  PU request: addr1 load plus memory read
- `req_addr2_from_pu`  in  1  PU request: addr2 load plus memory read
- `req_addr2_from_io`  in  1  I/O request: addr2 load plus memory read
- `hold_from_pnl`  in  1  while high, no new grant is started
- `clear_err_from_pnl`  in  1  clears the sticky timeout flag
- `mem_ack_from_mem`  in  1  memory read complete
- `do_arr_sel_to_sel`  out  1  load strobe to the select register
- `do_strt_to_sel`  out  1  load strobe to the select register
- `do_addr1_to_sel`  out  1  load strobe to the select register
- `do_addr2_to_sel_pu`  out  1  load strobe to the select register
- `do_addr2_to_sel_io`  out  1  load strobe to the select register
- `mem_req_to_mem`  out  1  memory read request; the address is the select register value
- `done_to_pnl`  out  1  one-cycle completion pulse
- `done_to_pu`  out  1  one-cycle completion pulse
- `done_to_io`  out  1  one-cycle completion pulse
- `busy`  out  1  FSM not in IDLE
- `pending_to_pnl`  out  5  pending bits, ordered `{io_addr2, pu_addr2, addr1, strt, arr_sel}`
- `timeout_err_to_pnl`  out  1  sticky timeout flag

## Operation

- **Request capture.** A request input sampled high sets its pending bit. Requests may be pulses or levels.
  - A request arriving while its own bit is already pending merges into that bit; it is not counted twice.
  - A pending bit clears on the edge that enters LOAD for that requester.
  - A request input that is still high on that same edge re-sets the bit, so the requester is served again.
- **Priority.** Fixed: arr_sel > strt > addr1 > addr2_pu > addr2_io. This order is evaluated only in IDLE.
- **FSM states:** IDLE, LOAD, MEM, DONE.
  - **IDLE:** if `hold_from_pnl` = 0 and any pending bit is set, latch the winner into a grant register and go to LOAD.
  - **LOAD (1 cycle):** assert exactly the granted `do_*` strobe.
    - arr_sel or strt grant: go to DONE.
    - Any other grant: go to MEM with the timeout counter cleared.
  - **MEM:**
    - `mem_req_to_mem` = 1 for the whole state.
    - The counter increments every cycle in MEM.
    - If `mem_ack_from_mem` is sampled high: go to DONE.
    - Else, if the counter has reached `TIMEOUT`: set `timeout_err_to_pnl` and go to DONE.
    - An ack in the same cycle as the timeout counts as success; the flag is not set.
  - **DONE (1 cycle):** pulse the `done_*` output of the granted unit, then go to IDLE.
    - `done_to_pu` covers strt, addr1 and addr2_pu grants.
- **Strobes and outputs.**
  - At most one `do_*` strobe is high in any cycle, and only in LOAD.
  - All outputs are registered or decoded from state and grant only; none has a combinational path from any input.
- **Sticky flag.** `clear_err_from_pnl` clears `timeout_err_to_pnl`. A set and a clear in the same cycle leave the flag set.
- **Hold.** `hold_from_pnl` does not abort a grant already in progress. Requests keep accumulating while hold is high.
- **Spurious ack.** `mem_ack_from_mem` outside MEM is ignored.
- **Reset (async, any state).**
  - FSM returns to IDLE; pending, grant, counter and the sticky flag clear.
  - Every output is 0 while reset is low and immediately after release.
  - A memory cycle interrupted by reset produces no `done` pulse.

## Timing

- Request sampled at edge E0 → pending visible at E0.
- IDLE→LOAD at E1 → strobe high E1–E2; the select register captures at E2.
- No-memory grants: `done` high E2–E3; back in IDLE at E3. The next grant enters LOAD at E4 at the earliest.
- Memory grants: `mem_req` rises at E2.
  - Ack sampled at edge Ek → `done` high Ek–Ek+1.
  - The fastest path (ack at E3) gives `done` at E3–E4.
- Timeout: with no ack, `mem_req` stays high for exactly `TIMEOUT` cycles. The flag sets on the same edge that enters DONE.
- `busy` = 1 from E1 until the edge that returns to IDLE.

## Test plan

- **Reset:** drive random requests, then assert `resetn` mid-MEM → all outputs 0 immediately; no `done` pulse after release.
- **Single panel request:** one-cycle pulse on `req_arr_sel_from_pnl` → `do_arr_sel_to_sel` high exactly one cycle after E1, `done_to_pnl` one cycle later, `mem_req_to_mem` never high.
- **Simultaneous requests:** pulse all five in one cycle → strobes occur in order arr_sel, strt, addr1, addr2_pu, addr2_io. Ack each memory grant 2 cycles after `mem_req` rises. Expect 3 `done_to_pu` pulses, 1 `done_to_pnl`, 1 `done_to_io`, and never two strobes in the same cycle.
- **Timeout:** `TIMEOUT`=15, `req_addr1_from_pu` pulsed, no ack → `mem_req` high exactly 15 cycles, then `done_to_pu`, `timeout_err_to_pnl`=1. It stays 1 until `clear_err_from_pnl` is pulsed.
- **Ack on timeout edge:** ack arrives in exactly the 15th MEM cycle → success path, `timeout_err_to_pnl` remains 0.
- **Hold:** `hold_from_pnl`=1 with `req_addr2_from_io` and then `req_strt_from_pu` pulsed → `pending_to_pnl`=5'b10010 and no strobes. Release hold → strt is served first, then io addr2.
